// File: rtl/sprite_overlay.sv
// Solid-colour sprite overlay for the VGA pixel path, moved by four direction buttons with auto-repeat.
// Define SPRITE_WRAP_EN to wrap the sprite to the opposite edge instead of clamping at the border.
module sprite_overlay #(
  parameter int unsigned H_RES        = 640,
  parameter int unsigned V_RES        = 480,
  parameter int unsigned SPR_W        = 20,
  parameter int unsigned SPR_H        = 20,
  parameter logic [7:0]  COLOR        = 8'hAA,
  parameter int unsigned ROW0         = 100,
  parameter int unsigned COL0         = 100,
  parameter int unsigned STEP         = 1,
  parameter int unsigned REPEAT_DELAY = 25000000,
  parameter int unsigned REPEAT_RATE  = 2500000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [18:0] address,
  input  logic [7:0]  qin,
  output logic [7:0]  qout,
  input  logic        left,
  input  logic        right,
  input  logic        up,
  input  logic        down,
  output logic [9:0]  pos_row,
  output logic [9:0]  pos_col
);

  localparam int unsigned CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned PIX_N   = H_RES * V_RES;
  localparam logic [9:0]  COL_LIM = 10'(H_RES - SPR_W);
  localparam logic [9:0]  ROW_LIM = 10'(V_RES - SPR_H);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_REPEAT} state_t;
  typedef enum logic [2:0] {DIR_NONE, DIR_LEFT, DIR_RIGHT, DIR_UP, DIR_DOWN} dir_t;

  state_t           state_q, state_d;
  dir_t             dir_q, dir_d, dir_c;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [9:0]       row_d, col_d;
  logic             step_c;

  logic [10:0] pix_row_c, pix_col_c;
  logic        in_range_c, hit_c;

  // Pixel decode against the current sprite rectangle
  assign pix_row_c  = 11'(32'(address) / H_RES);
  assign pix_col_c  = 11'(32'(address) % H_RES);
  assign in_range_c = 32'(address) < PIX_N;
  assign hit_c      = in_range_c
                   && (pix_row_c >= {1'b0, pos_row}) && (pix_row_c < ({1'b0, pos_row} + 11'(SPR_H)))
                   && (pix_col_c >= {1'b0, pos_col}) && (pix_col_c < ({1'b0, pos_col} + 11'(SPR_W)));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) qout <= 8'h00;
    else         qout <= hit_c ? COLOR : qin;
  end

  // One step along an axis in 11-bit signed, then clamp or wrap into [0, lim]
  function automatic logic [9:0] step_axis(input logic [9:0] pos, input logic inc, input logic [9:0] lim);
    logic signed [10:0] nxt;
    nxt = inc ? ($signed({1'b0, pos}) + $signed(11'(STEP)))
              : ($signed({1'b0, pos}) - $signed(11'(STEP)));
    if (nxt < 11'sd0) begin
`ifdef SPRITE_WRAP_EN
      step_axis = lim;
`else
      step_axis = 10'd0;
`endif
    end else if (nxt > $signed({1'b0, lim})) begin
`ifdef SPRITE_WRAP_EN
      step_axis = 10'd0;
`else
      step_axis = lim;
`endif
    end else begin
      step_axis = nxt[9:0];
    end
  endfunction

  always_comb begin
    dir_c = DIR_NONE;
    if      (left)  dir_c = DIR_LEFT;
    else if (right) dir_c = DIR_RIGHT;
    else if (up)    dir_c = DIR_UP;
    else if (down)  dir_c = DIR_DOWN;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      dir_q   <= DIR_NONE;
      cnt_q   <= '0;
      pos_row <= 10'(ROW0);
      pos_col <= 10'(COL0);
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      pos_row <= row_d;
      pos_col <= col_d;
    end
  end

  // Press / hold / auto-repeat sequencing and the resulting position update
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    step_c  = 1'b0;
    row_d   = pos_row;
    col_d   = pos_col;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (dir_c != DIR_NONE) begin
          step_c  = 1'b1;
          dir_d   = dir_c;
          state_d = S_HOLD;
        end
      end
      S_HOLD, S_REPEAT: begin
        if (dir_c == DIR_NONE) begin
          state_d = S_IDLE;
          dir_d   = DIR_NONE;
          cnt_d   = '0;
        end else if (dir_c != dir_q) begin
          step_c  = 1'b1;
          dir_d   = dir_c;
          cnt_d   = '0;
          state_d = S_HOLD;
        end else if ((state_q == S_HOLD)   && (cnt_q == CNT_W'(REPEAT_DELAY - 1)) ||
                     (state_q == S_REPEAT) && (cnt_q == CNT_W'(REPEAT_RATE - 1))) begin
          step_c  = 1'b1;
          cnt_d   = '0;
          state_d = S_REPEAT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        dir_d   = DIR_NONE;
        cnt_d   = '0;
      end
    endcase

    if (step_c) begin
      case (dir_c)
        DIR_LEFT:  col_d = step_axis(pos_col, 1'b0, COL_LIM);
        DIR_RIGHT: col_d = step_axis(pos_col, 1'b1, COL_LIM);
        DIR_UP:    row_d = step_axis(pos_row, 1'b0, ROW_LIM);
        DIR_DOWN:  row_d = step_axis(pos_row, 1'b1, ROW_LIM);
        default: ;
      endcase
    end
  end

endmodule
